// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types for the PLL reset/lock supervisor: sequencer states and counter sizing.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    ST_PLLRST = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STABLE = 2'd2,
    ST_RUN    = 2'd3
  } seq_state_e;

  // One shared cycle counter serves every timed state, so it is sized for the longest interval.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL-side and system-side signals of the reset sequencer, bundled for the top-level port.
interface pll_reset_sequencer_if;
  logic       pll_locked;
  logic       usr_rst;
  logic       pll_rst;
  logic       sys_rst_n;
  logic [1:0] seq_state;
  logic [7:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  modport master (
    input  pll_locked, usr_rst,
    output pll_rst, sys_rst_n, seq_state, retry_cnt, lock_loss_cnt
  );

  modport slave (
    output pll_locked, usr_rst,
    input  pll_rst, sys_rst_n, seq_state, retry_cnt, lock_loss_cnt
  );
endinterface

// File: rtl/pll_reset_sequencer_sync.sv
// Two-flop single-bit synchroniser with asynchronous active-low clear.
module sync_ff2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock supervisor on the reference clock: pulses PLL reset, qualifies lock, gates system reset.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 1048576,
  parameter int LOCK_STABLE_CYCLES  = 65536
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pll_reset_sequencer_if.master bus
);
  localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

  seq_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             locked_s, usr_s;
  logic             retry_inc, loss_inc;
  logic             pll_rst_q, sys_rst_n_q;
  logic [7:0]       retry_q, loss_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  sync_ff2 u_sync_lock (.clk(clk), .rst_n(rst_n), .d(bus.pll_locked), .q(locked_s));
  sync_ff2 u_sync_usr  (.clk(clk), .rst_n(rst_n), .d(bus.usr_rst),    .q(usr_s));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    case (state)
      ST_PLLRST: begin
        if (cnt == RST_LAST) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT: begin
        if (locked_s) begin
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TMO_LAST) begin
          state_nxt = ST_PLLRST;
          cnt_nxt   = '0;
          retry_inc = 1'b1;
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        cnt_nxt = cnt;
        if (!locked_s) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = '0;
          loss_inc  = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_PLLRST;
        cnt_nxt   = '0;
      end
    endcase
    // A user request overrides everything, but a simultaneous lock loss in RUN is still recorded.
    if (usr_s) begin
      state_nxt = ST_PLLRST;
      cnt_nxt   = '0;
      retry_inc = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_PLLRST;
      cnt         <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      retry_q     <= '0;
      loss_q      <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pll_rst_q   <= (state_nxt == ST_PLLRST);
      sys_rst_n_q <= (state_nxt == ST_RUN);
      if (retry_inc) retry_q <= sat_inc(retry_q);
      if (loss_inc)  loss_q  <= sat_inc(loss_q);
    end
  end

  assign bus.pll_rst       = pll_rst_q;
  assign bus.sys_rst_n     = sys_rst_n_q;
  assign bus.seq_state     = state;
  assign bus.retry_cnt     = retry_q;
  assign bus.lock_loss_cnt = loss_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed timing scenarios plus random lock/user-reset traffic vs a dwell-time model.
module tb_pll_reset_sequencer;
  localparam int PR = 4;
  localparam int TO = 32;
  localparam int ST = 8;
  localparam int P_PLLRST = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(PR), .LOCK_TIMEOUT_CYCLES(TO), .LOCK_STABLE_CYCLES(ST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: phase plus cycles spent in it; synchronisers seen as a two-sample input history.
  int m_phase, m_dwell, m_retry, m_loss;
  bit m_lk[2], m_us[2];
  bit m_ls, m_usr;

  task automatic enter(input int p);
    m_phase = p;
    m_dwell = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enter(P_PLLRST);
      m_retry = 0; m_loss = 0;
      m_lk[0] = 0; m_lk[1] = 0; m_us[0] = 0; m_us[1] = 0;
    end else begin
      m_ls  = m_lk[1];
      m_usr = m_us[1];
      m_lk[1] = m_lk[0]; m_lk[0] = bus.pll_locked;
      m_us[1] = m_us[0]; m_us[0] = bus.usr_rst;
      if (m_usr) begin
        if (m_phase == P_RUN && !m_ls) m_loss = (m_loss < 255) ? m_loss + 1 : 255;
        enter(P_PLLRST);
      end else if (m_phase == P_PLLRST) begin
        m_dwell++;
        if (m_dwell == PR) enter(P_WAIT);
      end else if (m_phase == P_WAIT) begin
        if (m_ls) enter(P_STABLE);
        else begin
          m_dwell++;
          if (m_dwell == TO) begin
            m_retry = (m_retry < 255) ? m_retry + 1 : 255;
            enter(P_PLLRST);
          end
        end
      end else if (m_phase == P_STABLE) begin
        if (!m_ls) enter(P_WAIT);
        else begin
          m_dwell++;
          if (m_dwell == ST) enter(P_RUN);
        end
      end else if (!m_ls) begin
        m_loss = (m_loss < 255) ? m_loss + 1 : 255;
        enter(P_WAIT);
      end
    end
  end

  always @(negedge clk) begin
    check("mdl_pll_rst",   int'(bus.pll_rst),       int'(m_phase == P_PLLRST));
    check("mdl_sys_rst_n", int'(bus.sys_rst_n),     int'(m_phase == P_RUN));
    check("mdl_state",     int'(bus.seq_state),     m_phase);
    check("mdl_retry",     int'(bus.retry_cnt),     m_retry);
    check("mdl_loss",      int'(bus.lock_loss_cnt), m_loss);
  end

  initial begin
    int n, tmo;
    bus.pll_locked = 1'b1;
    bus.usr_rst    = 1'b0;

    // 1: reset values, then power-up with lock already present
    repeat (2) @(negedge clk);
    check("rst_pll_rst",   int'(bus.pll_rst), 1);
    check("rst_sys_rst_n", int'(bus.sys_rst_n), 0);
    check("rst_state",     int'(bus.seq_state), 0);
    check("rst_retry",     int'(bus.retry_cnt), 0);
    check("rst_loss",      int'(bus.lock_loss_cnt), 0);
    rst_n = 1'b1;
    n = 0;
    while (bus.pll_rst && n < 100) begin n++; @(negedge clk); end
    check("t1_pll_rst_hi", n, PR);
    n = 0;
    while (!bus.sys_rst_n && n < 100) begin n++; @(negedge clk); end
    check("t1_sys_rise_edges", n, ST + 1);
    check("t1_state_run", int'(bus.seq_state), P_RUN);

    // 4: lock loss while running
    bus.pll_locked = 1'b0;
    n = 0;
    while (bus.sys_rst_n && n < 20) begin @(negedge clk); n++; end
    check("t4_sys_fall_edges", n, 3);
    check("t4_loss", int'(bus.lock_loss_cnt), 1);
    check("t4_state_wait", int'(bus.seq_state), P_WAIT);
    check("t4_pll_rst", int'(bus.pll_rst), 0);

    // 2: lock never arrives, PLL reset re-pulses on every timeout
    n = 0;
    while (!bus.pll_rst && n < 100) begin @(negedge clk); n++; end
    for (int i = 1; i <= 3; i++) begin
      check("t2_retry", int'(bus.retry_cnt), i);
      n = 0;
      while (bus.pll_rst && n < 100) begin n++; @(negedge clk); end
      check("t2_pll_rst_hi", n, PR);
      n = 0;
      while (!bus.pll_rst && n < 100) begin
        if (bus.sys_rst_n) check("t2_sys_rst_n", 1, 0);
        n++; @(negedge clk);
      end
      check("t2_pll_rst_lo", n, TO);
    end

    // 3: one-cycle lock glitch during STABLE restarts qualification
    bus.pll_locked = 1'b1;
    n = 0;
    while (bus.seq_state != 2'(P_STABLE) && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    bus.pll_locked = 1'b0;
    @(negedge clk);
    bus.pll_locked = 1'b1;
    repeat (2) @(negedge clk);
    check("t3_state_wait", int'(bus.seq_state), P_WAIT);
    check("t3_sys_rst_n", int'(bus.sys_rst_n), 0);
    n = 0;
    while (!bus.sys_rst_n && n < 100) begin n++; @(negedge clk); end
    check("t3_relock_edges", n, ST + 1);

    // 5: two-cycle user reset from RUN; the second request cycle keeps the pulse counter cleared
    bus.usr_rst = 1'b1;
    n = 0;
    while (!bus.pll_rst && n < 20) begin
      @(negedge clk); n++;
      if (n == 2) bus.usr_rst = 1'b0;
    end
    bus.usr_rst = 1'b0;
    check("t5_pll_rst_edges", n, 3);
    check("t5_sys_rst_n", int'(bus.sys_rst_n), 0);
    n = 0;
    while (bus.pll_rst && n < 100) begin n++; @(negedge clk); end
    check("t5_pll_rst_hi", n, PR + 1);
    n = 0;
    while (!bus.sys_rst_n && n < 100) begin n++; @(negedge clk); end
    check("t5_relock_edges", n, ST + 1);
    check("t5_state_run", int'(bus.seq_state), P_RUN);

    // 6: asynchronous reset mid-STABLE, then saturate the lock-loss counter
    bus.pll_locked = 1'b0;
    repeat (4) @(negedge clk);
    bus.pll_locked = 1'b1;
    n = 0;
    while (bus.seq_state != 2'(P_STABLE) && n < 100) begin @(negedge clk); n++; end
    check("t6_in_stable", int'(bus.seq_state), P_STABLE);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_pll_rst", int'(bus.pll_rst), 1);
    check("t6_async_sys_rst_n", int'(bus.sys_rst_n), 0);
    check("t6_async_state", int'(bus.seq_state), 0);
    check("t6_async_retry", int'(bus.retry_cnt), 0);
    check("t6_async_loss", int'(bus.lock_loss_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tmo = 0;
    for (int i = 0; i < 300; i++) begin
      n = 0;
      while (!bus.sys_rst_n && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) tmo++;
      bus.pll_locked = 1'b0;
      n = 0;
      while (bus.sys_rst_n && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) tmo++;
      bus.pll_locked = 1'b1;
    end
    check("t6_timeouts", tmo, 0);
    check("t6_loss_sat", int'(bus.lock_loss_cnt), 255);

    // random lock segments with sparse user resets
    for (int s = 0; s < 200; s++) begin
      int dur;
      bus.pll_locked = ($urandom_range(0, 3) != 0);
      dur = $urandom_range(1, 40);
      for (int c = 0; c < dur; c++) begin
        bus.usr_rst = ($urandom_range(0, 59) == 0);
        @(negedge clk);
      end
    end
    bus.usr_rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
